// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
// Contents: FSM state enum, default SYNC byte, error codes reported to the host,
// and the operand/result address-width helper.
package matmul_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSize    = 3'd1,
    StRecvA   = 3'd2,
    StRecvB   = 3'd3,
    StCompute = 3'd4,
    StRd      = 3'd5,
    StTx      = 3'd6,
    StErr     = 3'd7
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ERR_BAD_SIZE  = 8'hE1;
  localparam logic [7:0] ERR_TIMEOUT   = 8'hE2;

  // Address width for a max_n x max_n array; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned max_n);
    return (max_n * max_n > 1) ? $clog2(max_n * max_n) : 1;
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Bus bundle between the sequencer and its surroundings (UART, operand/result memories,
// multiplier, debug status).
// master: sequencer side. slave: environment side.
interface matmul_seq_ctrl_if #(
  parameter int unsigned MAX_N     = 8,
  parameter int unsigned RES_BYTES = 2
);
  localparam int unsigned AW = matmul_pkg::addr_width(MAX_N);

  logic                   rx_valid;
  logic [7:0]             rx_data;
  logic                   tx_busy;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   mem_we_a;
  logic                   mem_we_b;
  logic [AW-1:0]          mem_waddr;
  logic [7:0]             mem_wdata;
  logic                   mult_start;
  logic                   mult_done;
  logic [3:0]             matrix_size;
  logic [AW-1:0]          res_raddr;
  logic [8*RES_BYTES-1:0] res_rdata;
  logic                   busy;
  logic                   error;
  logic [2:0]             state;

  modport master (
    input  rx_valid, rx_data, tx_busy, mult_done, res_rdata,
    output tx_start, tx_data, mem_we_a, mem_we_b, mem_waddr, mem_wdata, mult_start,
           matrix_size, res_raddr, busy, error, state
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, mult_done, res_rdata,
    input  tx_start, tx_data, mem_we_a, mem_we_b, mem_waddr, mem_wdata, mult_start,
           matrix_size, res_raddr, busy, error, state
  );

endinterface

// File: rtl/matmul_tx_serializer.sv
// Result serializer: loads one result word and emits its RES_BYTES bytes MSB first
// through the UART transmitter handshake.
// Ports: clk/rst, load_i + word_i (start a word), tx_busy_i (transmitter busy),
// tx_start_o/tx_data_o (one-cycle request, data held with it), done_o (high in the
// cycle the last byte's tx_start is out).
module matmul_tx_serializer #(
  parameter int unsigned RES_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [8*RES_BYTES-1:0] word_i,
  input  logic                   tx_busy_i,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  output logic                   done_o
);
  localparam int unsigned WW = 8 * RES_BYTES;
  localparam int unsigned IW = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

  logic [WW-1:0] shreg_q, shreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          active_q, active_d;
  logic          start_q, start_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          issue, last;

  // start_q blocks back-to-back requests: tx_busy only rises a cycle after tx_start.
  assign issue = active_q && !tx_busy_i && !start_q;
  assign last  = (idx_q == IW'(RES_BYTES - 1));

  always_comb begin
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    active_d = active_q;
    start_d  = 1'b0;
    data_d   = data_q;
    done_d   = 1'b0;
    if (load_i) begin
      shreg_d  = word_i;
      idx_d    = '0;
      active_d = 1'b1;
    end else if (issue) begin
      start_d = 1'b1;
      data_d  = shreg_q[WW-1 -: 8];
      shreg_d = shreg_q << 8;
      if (last) begin
        idx_d    = '0;
        active_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      start_q  <= start_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;
  assign done_o     = done_q;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Session sequencer for the UART matrix-multiply datapath.
// Frames SYNC, size N, N*N bytes of A, N*N bytes of B, multiplier run, then streams
// N*N results of RES_BYTES bytes each. Bad sizes and inter-byte timeouts send an
// error code and set a sticky error flag.
// Ports: clk, rst (sync, active high), bus (master side of matmul_seq_ctrl_if:
// UART rx/tx, operand write ports, multiplier start/done, result read port, status).
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned MAX_N     = 8,
  parameter int unsigned RES_BYTES = 2,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  matmul_seq_ctrl_if.master bus
);
  localparam int unsigned AW     = addr_width(MAX_N);
  localparam int unsigned TW     = $clog2(TIMEOUT) + 1;
  localparam logic [7:0]  MaxN8  = 8'(MAX_N);

  state_e        state_q, state_d;
  logic [3:0]    row_q, row_d, col_q, col_d, size_q, size_d;
  logic [7:0]    err_code_q, err_code_d;
  logic          error_q, error_d;
  logic          mult_start_q, mult_start_d;
  logic          err_start_q, err_start_d;
  logic          rd_wait_q, rd_wait_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          ser_load, ser_start, ser_done;
  logic [7:0]    ser_data;
  logic          tx_start_w;
  logic          last_col, last_row, elem_last, counting, timed_out;
  logic [3:0]    col_nx, row_nx;

  // Raster walk over the N x N element grid, shared by operand receive and result send.
  assign last_col  = (col_q == size_q - 4'd1);
  assign last_row  = (row_q == size_q - 4'd1);
  assign elem_last = last_col && last_row;
  assign col_nx    = last_col ? 4'd0 : col_q + 4'd1;
  assign row_nx    = last_col ? (last_row ? 4'd0 : row_q + 4'd1) : row_q;

  assign counting  = (state_q == StSize) || (state_q == StRecvA) || (state_q == StRecvB);
  // A byte arriving in the final cycle still counts.
  assign timed_out = counting && !bus.rx_valid && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    size_d       = size_q;
    err_code_d   = err_code_q;
    error_d      = error_q;
    mult_start_d = 1'b0;
    err_start_d  = 1'b0;
    rd_wait_d    = 1'b0;
    ser_load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          error_d = 1'b0;
          state_d = StSize;
        end
      end
      StSize: begin
        if (bus.rx_valid) begin
          if (bus.rx_data != 8'd0 && bus.rx_data <= MaxN8) begin
            size_d  = bus.rx_data[3:0];
            row_d   = '0;
            col_d   = '0;
            state_d = StRecvA;
          end else begin
            err_code_d = ERR_BAD_SIZE;
            state_d    = StErr;
          end
        end
      end
      StRecvA, StRecvB: begin
        if (bus.rx_valid) begin
          row_d = row_nx;
          col_d = col_nx;
          if (elem_last) begin
            if (state_q == StRecvA) begin
              state_d = StRecvB;
            end else begin
              state_d      = StCompute;
              mult_start_d = 1'b1;
            end
          end
        end
      end
      StCompute: begin
        // mult_start_q marks the first cycle; a stale done from a previous run is ignored.
        if (!mult_start_q && bus.mult_done) begin
          row_d   = '0;
          col_d   = '0;
          state_d = StRd;
        end
      end
      StRd: begin
        // First cycle presents the address, second sees the RAM output.
        if (rd_wait_q) begin
          ser_load = 1'b1;
          state_d  = StTx;
        end else begin
          rd_wait_d = 1'b1;
        end
      end
      StTx: begin
        if (ser_done) begin
          row_d   = row_nx;
          col_d   = col_nx;
          state_d = elem_last ? StIdle : StRd;
        end
      end
      StErr: begin
        if (!bus.tx_busy && !tx_start_w) begin
          err_start_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timed_out) begin
      err_code_d = ERR_TIMEOUT;
      state_d    = StErr;
    end
    if (state_d == StErr) begin
      error_d = 1'b1;
    end

    if (!counting || bus.rx_valid || state_d != state_q) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      size_q       <= '0;
      err_code_q   <= '0;
      error_q      <= 1'b0;
      mult_start_q <= 1'b0;
      err_start_q  <= 1'b0;
      rd_wait_q    <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      size_q       <= size_d;
      err_code_q   <= err_code_d;
      error_q      <= error_d;
      mult_start_q <= mult_start_d;
      err_start_q  <= err_start_d;
      rd_wait_q    <= rd_wait_d;
      tmo_q        <= tmo_d;
    end
  end

  matmul_tx_serializer #(
    .RES_BYTES (RES_BYTES)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load),
    .word_i     (bus.res_rdata),
    .tx_busy_i  (bus.tx_busy),
    .tx_start_o (ser_start),
    .tx_data_o  (ser_data),
    .done_o     (ser_done)
  );

  // The error byte and result bytes never overlap in time.
  assign tx_start_w      = ser_start | err_start_q;
  assign bus.tx_start    = tx_start_w;
  assign bus.tx_data     = err_start_q ? err_code_q : ser_data;

  assign bus.mem_we_a    = bus.rx_valid && (state_q == StRecvA);
  assign bus.mem_we_b    = bus.rx_valid && (state_q == StRecvB);
  assign bus.mem_waddr   = AW'(row_q) * AW'(MAX_N) + AW'(col_q);
  assign bus.mem_wdata   = bus.rx_data;
  assign bus.res_raddr   = AW'(row_q) * AW'(MAX_N) + AW'(col_q);
  assign bus.mult_start  = mult_start_q;
  assign bus.matrix_size = size_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.error       = error_q;
  assign bus.state       = state_q;

endmodule
